alu_seq_param: RTL

Parametrised, fully registered successor to the 16-bit four-op ALU.
- WIDTH-generic operands.
- Eight ops: add, sub, mul, div, rem, and, or, xor.
- Double-width product and separate remainder outputs, plus status flags.
- Iterative shift-add multiplier and restoring divider built into one FSM with a shared counter.
- Start/Busy/Done handshake; sits between the register file and the writeback mux of the datapath.

---
 rtl/alu_seq_param.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq_param.sv
// alu_seq_param: registered 8-op ALU, iterative shift-add MUL and restoring DIV/REM.
// Define ALU_SIGNED_EN to add the Signed input and Ovf output (two's complement MUL/DIV/REM).
module alu_seq_param #(
    parameter  int WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [2:0]       ALUOP,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef ALU_SIGNED_EN
    input  logic             Signed,
    output logic             Ovf,
`endif
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] ResultHi,
    output logic             Busy,
    output logic             Done,
    output logic             Carry,
    output logic             Zero,
    output logic             DivZero
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_REM = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b110;
    localparam logic [2:0] OP_XOR = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] hi_q, lo_q;

    logic             is_md, long_op;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] hi_nxt, lo_nxt;
    logic [WIDTH:0]   mul_sum, r_sh;
    logic [WIDTH-1:0] r_sub;
    logic             ge;
    logic [WIDTH:0]   add_s, sub_s;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] quo, rmd;
    logic             dz_c;
    logic [WIDTH-1:0] res_c, hi_c;
    logic             carry_c;

`ifdef ALU_SIGNED_EN
    logic sgn_op, a_neg, b_neg;
    logic sgn_q, neg_p_q, neg_r_q;
    logic ovf_c;
`endif

    assign is_md   = (ALUOP == OP_MUL) || (ALUOP == OP_DIV) || (ALUOP == OP_REM);
    assign long_op = (ALUOP == OP_MUL) ||
                     (((ALUOP == OP_DIV) || (ALUOP == OP_REM)) && (B != '0));

    // Iterative engines work on magnitudes; signs are restored at FIN.
`ifdef ALU_SIGNED_EN
    always_comb begin
        sgn_op = Signed && is_md;
        a_neg  = sgn_op && A[WIDTH-1];
        b_neg  = sgn_op && B[WIDTH-1];
        a_mag  = a_neg ? -A : A;
        b_mag  = b_neg ? -B : B;
    end
`else
    always_comb begin
        a_mag = A;
        b_mag = B;
    end
`endif

    always_comb begin
        mul_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? d_q : {WIDTH{1'b0}})};
        r_sh    = {hi_q, lo_q[WIDTH-1]};
        ge      = (r_sh >= {1'b0, d_q});
        r_sub   = r_sh[WIDTH-1:0] - d_q;
        if (op_q == OP_MUL) begin
            hi_nxt = mul_sum[WIDTH:1];
            lo_nxt = {mul_sum[0], lo_q[WIDTH-1:1]};
        end else begin
            hi_nxt = ge ? r_sub : r_sh[WIDTH-1:0];
            lo_nxt = {lo_q[WIDTH-2:0], ge};
        end
    end

    always_comb begin
        add_s = {1'b0, a_q} + {1'b0, b_q};
        sub_s = {1'b0, a_q} + {1'b0, ~b_q} + (WIDTH+1)'(1);
        dz_c  = ((op_q == OP_DIV) || (op_q == OP_REM)) && (b_q == '0);
        prod  = {hi_q, lo_q};
        quo   = lo_q;
        rmd   = hi_q;
`ifdef ALU_SIGNED_EN
        if (neg_p_q) prod = -prod;
        if (neg_p_q) quo  = -quo;
        if (neg_r_q) rmd  = -rmd;
        ovf_c = sgn_q && ((op_q == OP_DIV) || (op_q == OP_REM)) &&
                (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);
`endif
    end

    always_comb begin
        res_c   = '0;
        hi_c    = '0;
        carry_c = 1'b0;
        unique case (op_q)
            OP_ADD: begin
                res_c   = add_s[WIDTH-1:0];
                carry_c = add_s[WIDTH];
            end
            OP_SUB: begin
                res_c   = sub_s[WIDTH-1:0];
                carry_c = sub_s[WIDTH];
            end
            OP_MUL: begin
                res_c = prod[WIDTH-1:0];
                hi_c  = prod[2*WIDTH-1:WIDTH];
            end
            OP_DIV: begin
                res_c = dz_c ? '1 : quo;
                hi_c  = dz_c ? a_q : rmd;
            end
            OP_REM: res_c = dz_c ? a_q : rmd;
            OP_AND: res_c = a_q & b_q;
            OP_OR:  res_c = a_q | b_q;
            OP_XOR: res_c = a_q ^ b_q;
            default: res_c = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (Start) state_d = long_op ? S_ITER : S_FIN;
            S_ITER: if (cnt_q == CNT_W'(1)) state_d = S_FIN;
            S_FIN:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            d_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            Result   <= '0;
            ResultHi <= '0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Carry    <= 1'b0;
            Zero     <= 1'b0;
            DivZero  <= 1'b0;
`ifdef ALU_SIGNED_EN
            sgn_q    <= 1'b0;
            neg_p_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            Ovf      <= 1'b0;
`endif
        end else begin
            Done <= 1'b0;
            unique case (state_q)
                S_IDLE: if (Start) begin
                    op_q  <= ALUOP;
                    a_q   <= A;
                    b_q   <= B;
                    Busy  <= 1'b1;
                    cnt_q <= CNT_W'(WIDTH);
                    hi_q  <= '0;
                    lo_q  <= (ALUOP == OP_MUL) ? b_mag : a_mag;
                    d_q   <= (ALUOP == OP_MUL) ? a_mag : b_mag;
`ifdef ALU_SIGNED_EN
                    sgn_q   <= sgn_op;
                    neg_p_q <= a_neg ^ b_neg;
                    neg_r_q <= a_neg;
`endif
                end
                S_ITER: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    hi_q  <= hi_nxt;
                    lo_q  <= lo_nxt;
                end
                S_FIN: begin
                    Busy     <= 1'b0;
                    Done     <= 1'b1;
                    Result   <= res_c;
                    ResultHi <= hi_c;
                    Carry    <= carry_c;
                    Zero     <= (res_c == '0);
                    DivZero  <= dz_c;
`ifdef ALU_SIGNED_EN
                    Ovf      <= ovf_c;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
